// File: rtl/sprite_blit.sv
// sprite_blit: copies one 32x32 tile from the tile ROM into the 640x480 framebuffer.
// Each pixel is clipped to the screen and dropped when it matches the colour key.
module sprite_blit #(
  parameter int TW_LOG = 5,
  parameter int TH_LOG = 5,
  parameter int IDX_W  = 4,
  parameter int SCR_W  = 640,
  parameter int SCR_H  = 480
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [IDX_W-1:0]                tile_idx,
  input  logic [9:0]                      left,
  input  logic [9:0]                      top,
  input  logic                            key_en,
  input  logic [15:0]                     key_color,
  output logic                            busy,
  output logic                            done,
  output logic [IDX_W+TH_LOG+TW_LOG-1:0]  rom_addr,
  input  logic [15:0]                     rom_data,
  output logic [18:0]                     dst_addr,
  output logic [15:0]                     dst_data,
  output logic                            dst_wr
);
  localparam int PW = TH_LOG + TW_LOG;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [IDX_W-1:0] idx;
  logic [9:0] lft, tp;
  logic ken;
  logic [15:0] kcol;
  logic [PW-1:0] pix, pix_n;
  logic dr, ld, adv, v1, v2, vis1, vis2, wr;
  logic [10:0] x_n, y_n, x1, y1;
  logic [18:0] a2;
  // pix is the {row,col} currently on rom_addr; pix_n is the one issued this edge
  always_comb begin
    ld = state == IDLE && start;
    adv = state == RUN && !(&pix);
    pix_n = ld ? '0 : pix + 1'b1;
    x_n = 11'(ld ? left : lft) + 11'(pix_n[TW_LOG-1:0]);
    y_n = 11'(ld ? top : tp) + 11'(pix_n[PW-1:TW_LOG]);
    wr = v2 && vis2 && !(ken && rom_data == kcol);
    nxt = ld ? RUN :
          (state == RUN && &pix) ? DRAIN :
          (state == DRAIN && dr) ? DONE :
          state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      rom_addr <= '0;
      pix <= '0;
      dr <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      dst_wr <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      state <= nxt;
      busy <= nxt == RUN || nxt == DRAIN;
      done <= nxt == DONE;
      dr <= state == DRAIN && !dr;
      if (ld || adv) begin
        pix <= pix_n;
        rom_addr <= {(ld ? tile_idx : idx), pix_n};
      end
      v1 <= ld || adv;
      v2 <= v1;
      dst_wr <= wr;
      if (wr) begin
        dst_addr <= a2;
        dst_data <= rom_data;
      end
    end
  end
  // stage 1 rides alongside the ROM access, the second stage lines up with rom_data
  always_ff @(posedge clk) begin
    if (ld) begin
      idx <= tile_idx;
      lft <= left;
      tp <= top;
      ken <= key_en;
      kcol <= key_color;
    end
    x1 <= x_n;
    y1 <= y_n;
    vis1 <= x_n < 11'(SCR_W) && y_n < 11'(SCR_H);
    vis2 <= vis1;
    a2 <= (19'(y1) << 9) + (19'(y1) << 7) + 19'(x1);
  end
endmodule

// File: tb/tb_sprite_blit.sv
// tb_sprite_blit: table of blit scenarios checked against a per-pixel reference model
// and hand-computed first/last write, write count, busy window and done position.
module tb_sprite_blit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [3:0] tile_idx = '0;
  logic [9:0] left = '0, top = '0;
  logic key_en = 1'b0;
  logic [15:0] key_color = '0;
  logic busy, done, dst_wr;
  logic [13:0] rom_addr;
  logic [15:0] rom_data = '0, dst_data;
  logic [18:0] dst_addr;
  logic rom_mode = 1'b0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  sprite_blit dut (
    .clk(clk), .rstn(rstn), .start(start), .tile_idx(tile_idx), .left(left), .top(top),
    .key_en(key_en), .key_color(key_color), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_data(rom_data), .dst_addr(dst_addr), .dst_data(dst_data), .dst_wr(dst_wr)
  );

  always_ff @(posedge clk)
    rom_data <= rom_mode ? (rom_addr[0] ? 16'hF00F : 16'h0000) : 16'(rom_addr);

  typedef struct {
    int idx, lft, tp, ken, kcol, mode, rst_at, restart;
    int nwr, f_addr, f_data, f_t, l_addr, l_data, l_t, done_t;
  } vec_t;
  vec_t v[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input int vi);
    vec_t t = v[vi];
    int nw = 0, ft = 0, fa = 0, fd = 0, lt = 0, la = 0, ld = 0;
    int s_err = 0, b_err = 0, r_err = 0, d_cnt = 0, d_t = 0;
    int k, x, y, a, val, ea, ed;
    bit alive, ew;
    tile_idx = 4'(t.idx);
    left = 10'(t.lft);
    top = 10'(t.tp);
    key_en = t.ken != 0;
    key_color = 16'(t.kcol);
    rom_mode = t.mode != 0;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 1028; n++) begin
      @(negedge clk);
      alive = t.rst_at == 0 || n <= t.rst_at;
      k = n - 3;
      ew = 1'b0;
      ea = 0;
      ed = 0;
      if (alive && k >= 0 && k < 1024) begin
        x = t.lft + k % 32;
        y = t.tp + k / 32;
        a = t.idx * 1024 + k;
        val = t.mode != 0 ? (a % 2 == 1 ? 'hF00F : 0) : a % 65536;
        ew = x < 640 && y < 480 && !(t.ken != 0 && val == t.kcol);
        ea = y * 640 + x;
        ed = val;
      end
      if (dst_wr !== ew || (ew && (int'(dst_addr) != ea || int'(dst_data) != ed))) s_err++;
      if (busy !== (alive && n <= 1026)) b_err++;
      if (alive && n <= 1024 && int'(rom_addr) != t.idx * 1024 + n - 1) r_err++;
      if (done === 1'b1) begin
        d_cnt++;
        d_t = n;
      end
      if (dst_wr === 1'b1) begin
        nw++;
        if (ft == 0) begin
          ft = n;
          fa = int'(dst_addr);
          fd = int'(dst_data);
        end
        lt = n;
        la = int'(dst_addr);
        ld = int'(dst_data);
      end
      if (n == 1) begin
        start = 1'b0;
        tile_idx = ~tile_idx;
        left = 10'd3;
        top = 10'd7;
        key_en = ~key_en;
        key_color = ~key_color;
      end
      if (n == t.restart) begin
        start = 1'b1;
        left = 10'd5;
        top = 10'd5;
      end
      if (t.restart != 0 && n == t.restart + 1) start = 1'b0;
      if (n == t.rst_at) rstn = 1'b0;
      if (t.rst_at != 0 && n == t.rst_at + 1) rstn = 1'b1;
      if (t.rst_at == 0 && n == 1027) start = 1'b1;
      if (n == 1028) start = 1'b0;
    end
    chk($sformatf("v%0d nwr", vi), nw, t.nwr);
    if (t.nwr != 0) begin
      chk($sformatf("v%0d first_t", vi), ft, t.f_t);
      chk($sformatf("v%0d first_addr", vi), fa, t.f_addr);
      chk($sformatf("v%0d first_data", vi), fd, t.f_data);
      chk($sformatf("v%0d last_t", vi), lt, t.l_t);
      chk($sformatf("v%0d last_addr", vi), la, t.l_addr);
      chk($sformatf("v%0d last_data", vi), ld, t.l_data);
    end
    chk($sformatf("v%0d done_cnt", vi), d_cnt, t.done_t != 0 ? 1 : 0);
    chk($sformatf("v%0d done_t", vi), d_t, t.done_t);
    chk($sformatf("v%0d stream_err", vi), s_err, 0);
    chk($sformatf("v%0d busy_err", vi), b_err, 0);
    chk($sformatf("v%0d rom_err", vi), r_err, 0);
  endtask

  initial begin
    //        idx lft  tp  ken kcol  mode rst restart nwr  f_addr f_data f_t l_addr l_data  l_t  done
    v[0] = '{0, 100, 50, 0, 0,      0, 0,   0,   1024, 32100,  0,      3, 51971,  'h03FF, 1026, 1027};
    v[1] = '{0, 620, 470, 0, 0,     0, 0,   0,   200,  301420, 0,      3, 307199, 'h0133, 310,  1027};
    v[2] = '{0, 1000, 10, 0, 0,     0, 0,   0,   0,    0,      0,      0, 0,      0,      0,    1027};
    v[3] = '{0, 100, 50, 1, 0,      1, 0,   0,   512,  32101,  'hF00F, 4, 51971,  'hF00F, 1026, 1027};
    v[4] = '{3, 200, 100, 0, 0,     0, 0,   500, 1024, 64200,  'h0C00, 3, 84071,  'h0FFF, 1026, 1027};
    v[5] = '{0, 100, 50, 0, 0,      0, 303, 0,   301,  32100,  0,      3, 37872,  'h012C, 303,  0};
    v[6] = '{0, 100, 50, 0, 0,      0, 0,   0,   1024, 32100,  0,      3, 51971,  'h03FF, 1026, 1027};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst dst_wr", int'(dst_wr), 0);
    chk("rst dst_addr", int'(dst_addr), 0);
    chk("rst dst_data", int'(dst_data), 0);
    chk("rst rom_addr", int'(rom_addr), 0);
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 7; i++) run(i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sprite_blit.md
Name: sprite_blit

Overview:
- Sequencer that blits one 32x32 tile from the tile ROM into the 640x480 RGB framebuffer at a given screen position.
- Walks the tile in row-major order and issues ROM reads.
- Aligns each returned colour with its screen coordinate.
- Drops off-screen and colour-keyed pixels.
- Emits the same dst_addr/dst_data/dst_wr write stream the framebuffer bRAM port A consumes.
- Upstream is the game/scene controller, which issues start; downstream are the tile bROM and the framebuffer RAM.

Parameters:
- TW_LOG, 5, log2 of tile width in pixels (32).
- TH_LOG, 5, log2 of tile height in pixels (32).
- IDX_W, 4, tile index width; ROM address width is IDX_W+TH_LOG+TW_LOG (14).
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.

Ports:
- clk  in  1  system clock (100 MHz); the only clock.
- rstn  in  1  synchronous active-low reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- tile_idx  in  IDX_W  tile to draw; captured on accept.
- left  in  10  screen x of tile column 0; captured on accept.
- top  in  10  screen y of tile row 0; captured on accept.
- key_en  in  1  enable colour-key transparency; captured on accept.
- key_color  in  16  transparent colour; captured on accept.
- busy  out  1  blit in progress.
- done  out  1  one-cycle pulse when the blit completes.
- rom_addr  out  IDX_W+TH_LOG+TW_LOG  tile ROM address, {tile_idx,row,col}.
- rom_data  in  16  tile ROM data, valid exactly 1 cycle after rom_addr.
- dst_addr  out  19  framebuffer address, y*SCR_W+x.
- dst_data  out  16  pixel colour.
- dst_wr  out  1  framebuffer write strobe.

Behaviour:
- All outputs are registered.
- Reset (rstn=0 at a clk edge):
  - state=IDLE;
  - busy, done, dst_wr=0;
  - dst_addr, dst_data, rom_addr=0;
  - row/col counters=0;
  - pipeline valid bits cleared.
  - Reset during a blit aborts it: no dst_wr after the reset edge and no done pulse.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - If start=1 at edge T, capture tile_idx/left/top/key_en/key_color, zero row/col, and go to RUN.
  - busy=1 from T+1.
- RUN:
  - Each cycle present rom_addr={idx,row,col} for pixel k=row*32+col, k=0..1023.
  - Pixel k is presented at T+1+k; col increments and wraps 31->0 with row++.
  - After k=1023 is issued, go to DRAIN.
- Pipeline:
  - Stage 1 registers x=left+col and y=top+row, computed at 11 bits with no wrap.
  - Stage 1 also registers vis=(x<SCR_W)&&(y<SCR_H) and a valid bit, alongside the ROM access.
  - Stage 2, in the cycle rom_data is valid, registers:
    - dst_wr = valid & vis & !(key_en && rom_data==key_color);
    - dst_data = rom_data;
    - dst_addr = y*640+x (19 bits, computed as (y<<9)+(y<<7)+x).
  - The write for pixel k appears at T+3+k.
  - When dst_wr=0, dst_addr/dst_data hold their last values.
- DRAIN: 2 cycles to flush the pipeline; the last possible write is at T+1026.
- DONE:
  - At T+1027, done=1 for exactly one cycle and busy=0; return to IDLE.
  - start at T+1027 is ignored; start at T+1028 is accepted.
- busy=1 from T+1 through T+1026 inclusive.
- start while busy=1 is ignored. Input changes during a blit have no effect (captured copies are used).
- Clipping:
  - A tile partially off the right/bottom edge writes only its visible pixels.
  - A fully off-screen tile writes nothing but keeps identical timing, including done at T+1027.
  - left/top up to 1023 never alias back on-screen, because the sum is 11 bits.
- Throughput: 1 pixel per cycle; fixed 1027-cycle blit regardless of clipping or keying.

Test Plan:
- ROM model returns data=addr[15:0]; start with tile_idx=0, left=100, top=50, key_en=0 at T:
  - 1024 writes;
  - first write at T+3, addr 32100, data 0x0000;
  - last write at T+1026, addr 51971, data 0x03FF;
  - done at T+1027 only; busy high T+1..T+1026.
- left=620, top=470: exactly 200 writes (20 cols x 10 rows). First at addr 301420; last at addr 307199. done still at T+1027.
- left=1000, top=10: 0 writes, no dst_wr at all, done at T+1027.
- key_en=1, key_color=0x0000, ROM returns 0x0000 for even addresses and 0xF00F for odd: 512 writes, all with data 0xF00F, at odd-column addresses only.
- tile_idx=3: rom_addr spans 3072..4095 in order. A second start at T+500 with different left/top changes nothing; a start at T+1028 begins a new blit.
- rstn=0 for one cycle at T+303 during a blit: from that edge dst_wr=0, busy=0, and no done pulse. A subsequent start runs a full, correct blit.
